// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbiter sharing the register file write port
//               between the ALU write-back path and the load path. The
//               winning write is held in a one-stage write slot that drives
//               the register file. Read-after-write hazards against the two
//               read ports are resolved here. A saturating counter records
//               contested cycles for performance debug.
//               Optional feature macro: REGFILE_BYPASS_EN
//                 defined   -> hazarded reads are forwarded from the slot
//                 undefined -> hazarded reads raise rd_stall
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_req,
  input  logic [2:0] alu_addr,
  input  logic [7:0] alu_data,
  output logic       alu_gnt,
  input  logic       ld_req,
  input  logic [2:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       ld_gnt,
  output logic       wr_en,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [2:0] rd_sel1,
  input  logic [2:0] rd_sel2,
  input  logic [7:0] rf_data1,
  input  logic [7:0] rf_data2,
  output logic [7:0] rd_data1,
  output logic [7:0] rd_data2,
  output logic       rd_stall,
  output logic [7:0] conflict_cnt
);

  localparam logic       WIN_ALU  = 1'b0;
  localparam logic       WIN_LD   = 1'b1;
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  // Requester that won the most recent grant; the other one wins a contest.
  logic last_winner;
  logic any_gnt;
  logic hazard1;
  logic hazard2;

  // Grant decode: lone requester always wins, contest goes to the non-last winner.
  always_comb begin
    alu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    if (reset) begin
      if (alu_req && ld_req) begin
        alu_gnt = (last_winner == WIN_LD);
        ld_gnt  = (last_winner == WIN_ALU);
      end else begin
        alu_gnt = alu_req;
        ld_gnt  = ld_req;
      end
    end
  end

  assign any_gnt = alu_gnt | ld_gnt;

  // Round-robin pointer: remember who won every grant, contested or not.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_winner <= WIN_LD;
    end else if (any_gnt) begin
      last_winner <= ld_gnt ? WIN_LD : WIN_ALU;
    end
  end

  // Write slot: capture the winner, otherwise go invalid and hold address/data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= 3'd0;
      wr_data <= 8'h00;
    end else begin
      wr_en <= any_gnt;
      if (alu_gnt) begin
        wr_addr <= alu_addr;
        wr_data <= alu_data;
      end else if (ld_gnt) begin
        wr_addr <= ld_addr;
        wr_data <= ld_data;
      end
    end
  end

  // Contested-cycle counter, sticks at its maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_cnt <= 8'h00;
    end else if (alu_req && ld_req && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + 8'h01;
    end
  end

  // A read hits the slot when it targets the register being written this cycle.
  assign hazard1 = wr_en && (wr_addr == rd_sel1);
  assign hazard2 = wr_en && (wr_addr == rd_sel2);

`ifdef REGFILE_BYPASS_EN
  // Forward slot data to any hazarded read port; no stall is ever needed.
  always_comb begin
    rd_data1 = hazard1 ? wr_data : rf_data1;
    rd_data2 = hazard2 ? wr_data : rf_data2;
    rd_stall = 1'b0;
  end
`else
  // Pass raw register file data and ask the consumer to retry on a hazard.
  always_comb begin
    rd_data1 = rf_data1;
    rd_data2 = rf_data2;
    rd_stall = hazard1 | hazard2;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Scoreboard bench for regfile_write_arbiter. A cycle-level
//               reference model predicts grants, the counter and read
//               results; predicted writes are queued and matched by a
//               separate monitor watching the write slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic       clk;
  logic       reset;
  logic       alu_req, ld_req;
  logic [2:0] alu_addr, ld_addr;
  logic [7:0] alu_data, ld_data;
  logic       alu_gnt, ld_gnt;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_sel1, rd_sel2;
  logic [7:0] rf_data1, rf_data2;
  logic [7:0] rd_data1, rd_data2;
  logic       rd_stall;
  logic [7:0] conflict_cnt;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_gnt(alu_gnt),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_stall(rd_stall),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] rf_model[8];
  logic [7:0] ref_rf[8];

  // Reference state: who won last (0 ALU, 1 LD), counter, pending slot write.
  int         last_won = 1;
  int         ref_cnt = 0;
  bit         prev_v = 0;
  logic [2:0] prev_a = 3'd0;
  logic [7:0] prev_d = 8'h00;
  bit         model_ok = 0;
  bit         exp_ag, exp_lg;

  // Random requester state.
  bit         a_pend, l_pend;
  logic [2:0] a_a, l_a;
  logic [7:0] a_d, l_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file environment model driven by the DUT write port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en === 1'b1) rf_model[wr_addr] <= wr_data;
  end

  // Monitor: every cycle the write slot either retires the due write or is idle.
  always @(negedge clk) begin
    if (model_ok) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        chk("wr_en", {31'd0, wr_en}, 32'd1);
        chk("wr_addr", {29'd0, wr_addr}, {29'd0, mon_e.addr});
        chk("wr_data", {24'd0, wr_data}, {24'd0, mon_e.data});
      end else begin
        chk("wr_en_idle", {31'd0, wr_en}, 32'd0);
      end
    end
  end

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic step(input logic rn, input logic ar, input logic [2:0] aa, input logic [7:0] ad,
                      input logic lr, input logic [2:0] la, input logic [7:0] ldd,
                      input logic [2:0] s1, input logic [2:0] s2);
    bit ea, el, h1, h2;
    logic [7:0] e1, e2;
    logic es;
    wr_t w;
    reset = rn; alu_req = ar; alu_addr = aa; alu_data = ad;
    ld_req = lr; ld_addr = la; ld_data = ldd;
    rd_sel1 = s1; rd_sel2 = s2;
    rf_data1 = rf_model[s1]; rf_data2 = rf_model[s2];
    @(negedge clk);
    ea = 0; el = 0;
    if (rn) begin
      if (ar && lr) begin
        if (last_won == 1) ea = 1; else el = 1;
      end else begin
        ea = ar; el = lr;
      end
    end
    chk("alu_gnt", {31'd0, alu_gnt}, {31'd0, ea});
    chk("ld_gnt", {31'd0, ld_gnt}, {31'd0, el});
    if (model_ok) begin
      chk("conflict_cnt", {24'd0, conflict_cnt}, ref_cnt);
      h1 = prev_v && (prev_a == s1);
      h2 = prev_v && (prev_a == s2);
`ifdef REGFILE_BYPASS_EN
      e1 = h1 ? prev_d : rf_data1;
      e2 = h2 ? prev_d : rf_data2;
      es = 1'b0;
`else
      e1 = rf_data1;
      e2 = rf_data2;
      es = h1 | h2;
`endif
      chk("rd_data1", {24'd0, rd_data1}, {24'd0, e1});
      chk("rd_data2", {24'd0, rd_data2}, {24'd0, e2});
      chk("rd_stall", {31'd0, rd_stall}, {31'd0, es});
    end
    if (prev_v) ref_rf[prev_a] = prev_d;
    if (!rn) begin
      last_won = 1; ref_cnt = 0; prev_v = 0;
    end else begin
      if (ar && lr) ref_cnt = (ref_cnt == 255) ? 255 : ref_cnt + 1;
      prev_v = ea | el;
      if (ea) begin
        last_won = 0; prev_a = aa; prev_d = ad;
      end else if (el) begin
        last_won = 1; prev_a = la; prev_d = ldd;
      end
      if (prev_v) begin
        w.due = cyc + 1; w.addr = prev_a; w.data = prev_d;
        exp_q.push_back(w);
      end
    end
    exp_ag = ea; exp_lg = el;
    @(posedge clk);
    #1;
    if (!rn) model_ok = 1;
  endtask

  task automatic idle(input int n, input logic [2:0] s1, input logic [2:0] s2);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, s1, s2);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf_model[i] = 8'h00;
      ref_rf[i] = 8'h00;
    end
    reset = 0; alu_req = 0; ld_req = 0; alu_addr = 0; ld_addr = 0;
    alu_data = 0; ld_data = 0; rd_sel1 = 0; rd_sel2 = 0; rf_data1 = 0; rf_data2 = 0;
    @(posedge clk);
    #1;

    // Reset state and a single uncontested ALU write.
    do_reset();
    chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset_wr_addr", {29'd0, wr_addr}, 32'd0);
    chk("reset_wr_data", {24'd0, wr_data}, 32'd0);
    chk("reset_cnt", {24'd0, conflict_cnt}, 32'd0);
    step(1, 1, 3'd3, 8'h5A, 0, 0, 0, 0, 0);
    idle(2, 3, 1);

    // Continuous contention alternates ALU, LD, ALU, LD.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 2);
    chk("contend_cnt4", {24'd0, conflict_cnt}, 32'd4);
    idle(2, 1, 2);

    // Same destination: ALU first, LD second, LD's data wins.
    do_reset();
    step(1, 1, 3'd5, 8'hAA, 1, 3'd5, 8'hBB, 5, 0);
    step(1, 0, 0, 0, 1, 3'd5, 8'hBB, 5, 5);
    idle(2, 5, 0);
    chk("same_dest_r5", {24'd0, rf_model[5]}, 32'h0000_00BB);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) step(1, 1, 3'(i), 8'(i), 1, 3'(i + 3), 8'(i + 7), 3'(i), 3'(i + 1));
    chk("cnt_saturate", {24'd0, conflict_cnt}, 32'h0000_00FF);
    idle(2, 0, 0);

    // Read hazard on the register being written.
    do_reset();
    step(1, 1, 3'd4, 8'h3C, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 4, 7);
    idle(1, 4, 4);

    // Reset during a held load request, then re-present it.
    do_reset();
    step(1, 1, 3'd6, 8'h66, 1, 3'd7, 8'h77, 0, 0);
    step(0, 0, 0, 0, 1, 3'd7, 8'h77, 0, 0);
    step(0, 0, 0, 0, 1, 3'd7, 8'h77, 0, 0);
    chk("rst_hold_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_hold_cnt", {24'd0, conflict_cnt}, 32'd0);
    step(1, 0, 0, 0, 1, 3'd7, 8'h77, 7, 6);
    idle(2, 7, 6);

    // Randomized handshaking with withdrawals and random reads.
    a_pend = 0; l_pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!a_pend) begin
        if ($urandom_range(0, 1) == 1) begin
          a_pend = 1; a_a = 3'($urandom); a_d = 8'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        a_pend = 0;
      end
      if (!l_pend) begin
        if ($urandom_range(0, 1) == 1) begin
          l_pend = 1; l_a = 3'($urandom); l_d = 8'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        l_pend = 0;
      end
      step(1, a_pend, a_a, a_d, l_pend, l_a, l_d, 3'($urandom), 3'($urandom));
      if (exp_ag) a_pend = 0;
      if (exp_lg) l_pend = 0;
    end
    idle(3, 0, 0);

    chk("queue_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 8; i++) chk("final_rf", {24'd0, rf_model[i]}, {24'd0, ref_rf[i]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
